// File: rtl/iterative_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_shifter: multi-cycle SLL/SRL/SRA/ROTR unit, up to STEP bits/clk   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   WIDTH_C = (SHAMT_W+1)'(WIDTH);

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W:0]   rot_amt;
  logic [WIDTH-1:0]   shifted;

  // Per-cycle shift datapath; rotate is only consumed in SHIFT where step_amt >= 1.
  always_comb begin
    step_amt = (rem_q < STEP_C) ? rem_q : STEP_C;
    rot_amt  = WIDTH_C - {1'b0, step_amt};
    shifted  = acc_q;
    case (mode_q)
      MODE_SLL:  shifted = acc_q << step_amt;
      MODE_SRL:  shifted = acc_q >> step_amt;
      MODE_SRA:  shifted = WIDTH'($signed(acc_q) >>> step_amt);
      MODE_ROTR: shifted = (acc_q >> step_amt) | (acc_q << rot_amt);
      default:   shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = data_in;
          rem_d   = shamt;
          mode_d  = mode;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign data_out = acc_q;

endmodule
`default_nettype wire
